// File: rtl/shift_burst_generator_if.sv
// AXI-Stream bus carrying the per-epoch shift values from the burst generator
// to the Gold-code correlator/shifter bank.
interface shift_burst_generator_if #(
   parameter int DATA_W = 8
);
   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;
   logic              tlast;
   logic              tuser;

   modport master (
      output tvalid,
      output tdata,
      output tlast,
      output tuser,
      input  tready
   );

   modport slave (
      input  tvalid,
      input  tdata,
      input  tlast,
      input  tuser,
      output tready
   );
endinterface

// File: rtl/shift_burst_generator.sv
// Emits one burst of N arithmetic shift values (base, base+step, ...) per epoch.
// Define SHIFT_BURST_TLAST_EN to drive tlast on the final beat; otherwise tlast is 0.
module shift_burst_generator #(
   parameter int DATA_W    = 8,
   parameter int MAX_CODES = 16,
   parameter int CNT_W     = $clog2(MAX_CODES + 1),
   parameter int PERIOD_W  = 18,
   parameter int BCNT_W    = 16
) (
   input  logic                   clkin,
   input  logic                   rstn,
   input  logic                   enable,
   input  logic [CNT_W-1:0]       cfg_num_codes,
   input  logic [PERIOD_W-1:0]    cfg_period,
   input  logic [DATA_W-1:0]      cfg_base,
   input  logic [DATA_W-1:0]      cfg_step,
   shift_burst_generator_if.master m_axis,
   output logic                   epoch_tick,
   output logic                   overrun,
   output logic                   burst_active,
   output logic [BCNT_W-1:0]      burst_cnt
);

   localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_CODES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [PERIOD_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    n_q, n_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [DATA_W-1:0]   step_q, step_d;
   logic                tvalid_q, tvalid_d;
   logic [DATA_W-1:0]   tdata_q, tdata_d;
   logic                tuser_q, tuser_d;
   logic                tick_q, tick_d;
   logic                overrun_q, overrun_d;
   logic [BCNT_W-1:0]   bcnt_q, bcnt_d;

   logic tick_now;
   logic handshake;
   logic last_beat;
   logic start;

   function automatic logic [CNT_W-1:0] clamp_n(input logic [CNT_W-1:0] n);
      return (n > MAX_N) ? MAX_N : n;
   endfunction

   // A period of 0 behaves like 1, so both reload to 0 and tick every cycle.
   function automatic logic [PERIOD_W-1:0] reload_val(input logic [PERIOD_W-1:0] p);
      return (p == '0) ? '0 : p - PERIOD_W'(1);
   endfunction

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      idx_d     = idx_q;
      n_d       = n_q;
      period_d  = period_q;
      step_d    = step_q;
      tvalid_d  = tvalid_q;
      tdata_d   = tdata_q;
      tuser_d   = tuser_q;
      overrun_d = 1'b0;
      bcnt_d    = bcnt_q;
      start     = 1'b0;

      tick_now  = (state_q != IDLE) && (timer_q == '0);
      handshake = tvalid_q && m_axis.tready;
      last_beat = (idx_q == n_q - CNT_W'(1));
      tick_d    = tick_now;

      if (state_q != IDLE) begin
         timer_d = tick_now ? reload_val(period_q) : timer_q - PERIOD_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (enable) begin
               start = 1'b1;
            end
         end
         BURST: begin
            if (tick_now && !(handshake && last_beat)) begin
               overrun_d = 1'b1;
            end
            if (handshake) begin
               if (last_beat) begin
                  bcnt_d = bcnt_q + BCNT_W'(1);
                  if (!enable) begin
                     state_d  = IDLE;
                     tvalid_d = 1'b0;
                     tuser_d  = 1'b0;
                     idx_d    = '0;
                  end else if (tick_now) begin
                     start = 1'b1;
                  end else begin
                     state_d  = WAIT;
                     tvalid_d = 1'b0;
                     tuser_d  = 1'b0;
                     idx_d    = '0;
                  end
               end else begin
                  tdata_d = tdata_q + step_q;
                  tuser_d = 1'b0;
                  idx_d   = idx_q + CNT_W'(1);
               end
            end
         end
         WAIT: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (tick_now) begin
               start = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Every burst start re-samples the live configuration into the shadows.
      if (start) begin
         n_d      = clamp_n(cfg_num_codes);
         period_d = cfg_period;
         step_d   = cfg_step;
         timer_d  = reload_val(cfg_period);
         idx_d    = '0;
         if (n_d != '0) begin
            state_d  = BURST;
            tvalid_d = 1'b1;
            tdata_d  = cfg_base;
            tuser_d  = 1'b1;
         end else begin
            state_d  = WAIT;
            tvalid_d = 1'b0;
            tuser_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clkin) begin
      if (!rstn) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         idx_q     <= '0;
         n_q       <= '0;
         period_q  <= '0;
         step_q    <= '0;
         tvalid_q  <= 1'b0;
         tdata_q   <= '0;
         tuser_q   <= 1'b0;
         tick_q    <= 1'b0;
         overrun_q <= 1'b0;
         bcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         idx_q     <= idx_d;
         n_q       <= n_d;
         period_q  <= period_d;
         step_q    <= step_d;
         tvalid_q  <= tvalid_d;
         tdata_q   <= tdata_d;
         tuser_q   <= tuser_d;
         tick_q    <= tick_d;
         overrun_q <= overrun_d;
         bcnt_q    <= bcnt_d;
      end
   end

`ifdef SHIFT_BURST_TLAST_EN
   logic tlast_q, tlast_d;

   // Derived from next-state index so tlast follows the data it belongs to.
   always_comb begin
      tlast_d = tvalid_d && (idx_d == n_d - CNT_W'(1));
   end

   always_ff @(posedge clkin) begin
      if (!rstn) begin
         tlast_q <= 1'b0;
      end else begin
         tlast_q <= tlast_d;
      end
   end

   assign m_axis.tlast = tlast_q;
`else
   assign m_axis.tlast = 1'b0;
`endif

   assign m_axis.tvalid = tvalid_q;
   assign m_axis.tdata  = tdata_q;
   assign m_axis.tuser  = tuser_q;
   assign epoch_tick    = tick_q;
   assign overrun       = overrun_q;
   assign burst_active  = (state_q == BURST);
   assign burst_cnt     = bcnt_q;

endmodule

// File: tb/tb_shift_burst_generator.sv
// Directed-vector bench for shift_burst_generator: table-driven basic burst plus
// hand-written sequences for backpressure, overrun, back-to-back, enable drop and reset.
module tb_shift_burst_generator;

   logic        clkin;
   logic        rstn;
   logic        enable;
   logic [4:0]  cfg_num_codes;
   logic [17:0] cfg_period;
   logic [7:0]  cfg_base;
   logic [7:0]  cfg_step;
   logic        epoch_tick;
   logic        overrun;
   logic        burst_active;
   logic [15:0] burst_cnt;

   int total = 0;
   int bad   = 0;

   shift_burst_generator_if #(.DATA_W(8)) m_if ();

   shift_burst_generator dut (
      .clkin         (clkin),
      .rstn          (rstn),
      .enable        (enable),
      .cfg_num_codes (cfg_num_codes),
      .cfg_period    (cfg_period),
      .cfg_base      (cfg_base),
      .cfg_step      (cfg_step),
      .m_axis        (m_if),
      .epoch_tick    (epoch_tick),
      .overrun       (overrun),
      .burst_active  (burst_active),
      .burst_cnt     (burst_cnt)
   );

   initial clkin = 1'b0;
   always #5 clkin = ~clkin;

   typedef struct {
      logic        en;
      logic        rdy;
      int          adv;
      logic        v;
      logic [7:0]  d;
      logic        u;
      logic        l;
      logic        t;
      logic        o;
      logic        a;
      logic [15:0] b;
   } vec_t;

   task automatic step_clk();
      @(posedge clkin);
      #1;
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // tlast is only meaningful when the optional last-beat marker is built in.
   task automatic check_output(input string tag, input logic v, input logic [7:0] d,
                               input logic u, input logic l, input logic t, input logic o,
                               input logic a, input logic [15:0] b);
      logic exp_last;
`ifdef SHIFT_BURST_TLAST_EN
      exp_last = l;
`else
      exp_last = 1'b0;
`endif
      cmp({tag, ".tvalid"}, 32'(m_if.tvalid), 32'(v));
      if (v) cmp({tag, ".tdata"}, 32'(m_if.tdata), 32'(d));
      cmp({tag, ".tuser"}, 32'(m_if.tuser), 32'(u));
      cmp({tag, ".tlast"}, 32'(m_if.tlast), 32'(exp_last));
      cmp({tag, ".epoch_tick"}, 32'(epoch_tick), 32'(t));
      cmp({tag, ".overrun"}, 32'(overrun), 32'(o));
      cmp({tag, ".burst_active"}, 32'(burst_active), 32'(a));
      cmp({tag, ".burst_cnt"}, 32'(burst_cnt), 32'(b));
   endtask

   task automatic apply_stimulus(input logic [4:0] n, input logic [17:0] p,
                                 input logic [7:0] base, input logic [7:0] stp);
      cfg_num_codes = n;
      cfg_period    = p;
      cfg_base      = base;
      cfg_step      = stp;
   endtask

   task automatic do_reset();
      rstn       = 1'b0;
      enable     = 1'b0;
      m_if.tready = 1'b0;
      step_clk();
      step_clk();
      rstn = 1'b1;
   endtask

   initial begin
      vec_t        vecs[9];
      logic        bp_rdy[7];
      logic [7:0]  bp_dat[7];
      int          hs;
      logic [7:0]  exp_d;

      apply_stimulus(5'd0, 18'd0, 8'h00, 8'h00);
      do_reset();
      check_output("reset", 1'b0, 8'h00, 0, 0, 0, 0, 0, 16'd0);
      cmp("reset.tdata", 32'(m_if.tdata), 32'h0);

      // Basic burst: N=3, base 0, step 1, P=20; cycle k = after edge k-1.
      vecs[0] = '{1'b1, 1'b1, 1,  1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
      vecs[1] = '{1'b1, 1'b1, 1,  1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
      vecs[2] = '{1'b1, 1'b1, 1,  1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0};
      vecs[3] = '{1'b1, 1'b1, 1,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
      vecs[4] = '{1'b1, 1'b1, 16, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
      vecs[5] = '{1'b1, 1'b1, 1,  1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1};
      vecs[6] = '{1'b1, 1'b1, 1,  1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1};
      vecs[7] = '{1'b1, 1'b1, 1,  1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1};
      vecs[8] = '{1'b1, 1'b1, 1,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};

      apply_stimulus(5'd3, 18'd20, 8'h00, 8'h01);
      for (int i = 0; i < 9; i++) begin
         enable      = vecs[i].en;
         m_if.tready = vecs[i].rdy;
         repeat (vecs[i].adv) step_clk();
         check_output($sformatf("basic[%0d]", i), vecs[i].v, vecs[i].d, vecs[i].u,
                      vecs[i].l, vecs[i].t, vecs[i].o, vecs[i].a, vecs[i].b);
      end

      // Backpressure with tdata wrapping past 8'hFF.
      do_reset();
      apply_stimulus(5'd4, 18'd20, 8'hFE, 8'h01);
      bp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      bp_dat = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h01};
      hs = 0;
      enable      = 1'b1;
      m_if.tready = 1'b1;
      step_clk();
      for (int i = 0; i < 7; i++) begin
         m_if.tready = bp_rdy[i];
         check_output($sformatf("bp[%0d]", i), 1'b1, bp_dat[i], i == 0, i >= 5,
                      0, 0, 1, 16'd0);
         if (m_if.tvalid && m_if.tready) hs++;
         step_clk();
      end
      check_output("bp_end", 1'b0, 8'h00, 0, 0, 0, 0, 0, 16'd1);
      cmp("bp_handshakes", 32'(hs), 32'd4);

      // Overrun: P=3, ready low for cycles 1..10.
      do_reset();
      apply_stimulus(5'd5, 18'd3, 8'h10, 8'h03);
      enable      = 1'b1;
      m_if.tready = 1'b0;
      step_clk();
      for (int c = 1; c <= 16; c++) begin
         m_if.tready = (c >= 11);
         if (c <= 11 || c == 16) exp_d = 8'h10;
         else exp_d = 8'(8'h10 + 3 * (c - 11));
         check_output($sformatf("ovr[c%0d]", c), 1'b1, exp_d, (c <= 11) || (c == 16),
                      c == 15, (c >= 4) && ((c - 1) % 3 == 0),
                      (c == 4) || (c == 7) || (c == 10) || (c == 13), 1'b1,
                      (c == 16) ? 16'd1 : 16'd0);
         step_clk();
      end

      // Back-to-back single-beat bursts with P=0.
      do_reset();
      apply_stimulus(5'd1, 18'd0, 8'h07, 8'h05);
      enable      = 1'b1;
      m_if.tready = 1'b1;
      step_clk();
      for (int c = 1; c <= 8; c++) begin
         check_output($sformatf("b2b[c%0d]", c), 1'b1, 8'h07, 1'b1, 1'b1, c >= 2,
                      1'b0, 1'b1, 16'(c - 1));
         step_clk();
      end

      // Enable dropped at the second beat, then an empty-burst configuration.
      do_reset();
      apply_stimulus(5'd4, 18'd10, 8'h20, 8'h02);
      enable      = 1'b1;
      m_if.tready = 1'b1;
      step_clk();
      for (int c = 1; c <= 4; c++) begin
         if (c == 2) enable = 1'b0;
         check_output($sformatf("edrop[c%0d]", c), 1'b1, 8'(8'h20 + 2 * (c - 1)),
                      c == 1, c == 4, 0, 0, 1, 16'd0);
         step_clk();
      end
      for (int c = 5; c <= 20; c++) begin
         check_output($sformatf("idle[c%0d]", c), 1'b0, 8'h00, 0, 0, 0, 0, 0, 16'd1);
         if (c == 20) begin
            apply_stimulus(5'd0, 18'd4, 8'h20, 8'h02);
            enable = 1'b1;
         end
         step_clk();
      end
      for (int c = 21; c <= 32; c++) begin
         check_output($sformatf("n0[c%0d]", c), 1'b0, 8'h00, 0, 0,
                      (c == 25) || (c == 29), 0, 0, 16'd1);
         step_clk();
      end

      // Reset during the second beat of the second burst.
      do_reset();
      apply_stimulus(5'd6, 18'd10, 8'h40, 8'h01);
      enable      = 1'b1;
      m_if.tready = 1'b1;
      repeat (11) step_clk();
      check_output("rst_c11", 1'b1, 8'h40, 1, 0, 1, 0, 1, 16'd1);
      step_clk();
      check_output("rst_c12", 1'b1, 8'h41, 0, 0, 0, 0, 1, 16'd1);
      rstn   = 1'b0;
      enable = 1'b0;
      step_clk();
      check_output("rst_c13", 1'b0, 8'h00, 0, 0, 0, 0, 0, 16'd0);
      cmp("rst_c13.tdata", 32'(m_if.tdata), 32'h0);
      rstn = 1'b1;
      step_clk();
      check_output("rst_c14", 1'b0, 8'h00, 0, 0, 0, 0, 0, 16'd0);
      enable = 1'b1;
      step_clk();
      check_output("rst_c15", 1'b1, 8'h40, 1, 0, 0, 0, 1, 16'd0);
      step_clk();
      check_output("rst_c16", 1'b1, 8'h41, 0, 0, 0, 0, 1, 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
